// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The loader takes the slave modport; the byte source and memory take the master side.
interface prog_loader_if #(
    parameter int W  = 17,
    parameter int AW = 8
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [W-1:0]  mem_data;
    logic [AW-1:0] mem_ad;
    logic          mem_we;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_data,
        output mem_ad,
        output mem_we
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_data,
        input  mem_ad,
        input  mem_we
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a count/word/checksum byte stream into memory
// writes and holds the processor in reset until the load is complete.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for the count byte N
// S_B0    | waiting for word byte 0 (bits 7:0)
// S_B1    | waiting for word byte 1 (bits 15:8)
// S_B2    | waiting for word byte 2 (bit 16, bits 7:1 must be zero)
// S_WRITE | one-cycle memory write of the assembled word
// S_CHK   | waiting for the checksum byte
// S_DONE  | load finished, processor released, waiting for start
module prog_loader #(
    parameter int W  = 17,
    parameter int AW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_B0    = 3'd1,
        S_B1    = 3'd2,
        S_B2    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    n_q, n_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic [W-1:0]  mem_data_q, mem_data_d;
    logic [AW-1:0] mem_ad_q, mem_ad_d;
    logic          err_q, err_d;

    logic          in_ready;
    logic          accept;
    logic [16:0]   word;
    logic [7:0]    cnt_inc;

    assign accept  = bus.in_valid && in_ready;
    assign word    = {bus.in_data[0], b1_q, b0_q};
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            xor_q      <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            mem_data_q <= '0;
            mem_ad_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            xor_q      <= xor_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            mem_data_q <= mem_data_d;
            mem_ad_q   <= mem_ad_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        xor_d      = xor_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        mem_data_d = mem_data_q;
        mem_ad_d   = mem_ad_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    n_d     = bus.in_data;
                    xor_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = (bus.in_data != 8'd0) ? S_B0 : S_CHK;
                end
            end
            S_B0: begin
                if (accept) begin
                    b0_d    = bus.in_data;
                    xor_d   = xor_q ^ bus.in_data;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (accept) begin
                    b1_d    = bus.in_data;
                    xor_d   = xor_q ^ bus.in_data;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (accept) begin
                    xor_d = xor_q ^ bus.in_data;
                    // Upper bits of byte 2 are a format violation but the word is still written.
                    if (bus.in_data[7:1] != 7'd0) begin
                        err_d = 1'b1;
                    end
                    mem_data_d = W'(word);
                    mem_ad_d   = AW'(cnt_q);
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == n_q) ? S_CHK : S_B0;
            end
            S_CHK: begin
                if (accept) begin
                    if (bus.in_data != xor_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        cpu_rst_n = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_WRITE: begin
                in_ready = 1'b0;
            end
            S_DONE: begin
                in_ready  = 1'b0;
                busy      = 1'b0;
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_we   = (state_q == S_WRITE);
    assign bus.mem_data = mem_data_q;
    assign bus.mem_ad   = mem_ad_q;
    assign err          = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter W, default 17, meaning the memory word width in bits.
REQ-002 The block SHALL have parameter AW, default 8, meaning the memory address width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port start  input  1  re-arm pulse, honoured only in DONE.
REQ-006 The block SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 The block SHALL have port in_data  input  8  byte-stream data.
REQ-008 The block SHALL have port in_ready  output  1  byte-stream ready.
REQ-009 The block SHALL have port mem_data  output  W  write data to the program memory.
REQ-010 The block SHALL have port mem_ad  output  AW  memory address.
REQ-011 The block SHALL have port mem_we  output  1  memory write enable; the memory samples on the same clk edge.
REQ-012 The block SHALL have port busy  output  1  load in progress.
REQ-013 The block SHALL have port done  output  1  load finished.
REQ-014 The block SHALL have port err  output  1  sticky format or checksum error.
REQ-015 The block SHALL have port cpu_rst_n  output  1  processor hold; low until done.

Function
REQ-016 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both high; in_valid may stay high across cycles without duplicating a byte.
REQ-017 Stream format SHALL be: count byte N, then N words of 3 bytes each (byte0 = bits 7:0, byte1 = bits 15:8, byte2 bit0 = bit 16), then 1 checksum byte.
REQ-018 Byte2 bits 7:1 nonzero SHALL set err; the word is still written with those bits ignored.
REQ-019 Checksum SHALL be the XOR of N and all data bytes; a mismatch SHALL set err.
REQ-020 States SHALL be IDLE, B0, B1, B2, WRITE, CHK and DONE.
REQ-021 IDLE: in_ready=1; accepting a byte SHALL latch N, seed the XOR, clear the word counter and go to B0 if N>0, else to CHK.
REQ-022 B0 and B1: in_ready=1; each accepted byte SHALL be latched and advance the state to B1 and B2 respectively.
REQ-023 B2: in_ready=1; an accepted byte SHALL complete the word and go to WRITE.
REQ-024 WRITE: in_ready=0 and mem_we=1 for exactly one cycle, with mem_ad set to the word counter and mem_data set to the assembled word.
REQ-025 After WRITE, the counter SHALL increment and the state SHALL go to CHK if the counter equals N, else to B0.
REQ-026 The address SHALL start at 0 and increase by 1 per word; N max is 255, so there is no wrap.
REQ-027 CHK: in_ready=1; the accepted byte SHALL be compared with the XOR and the state SHALL go to DONE.
REQ-028 DONE: in_ready=0; done=1; cpu_rst_n=1; start=1 SHALL go to IDLE and clear done and err, and cpu_rst_n SHALL return low.
REQ-029 start outside DONE SHALL be ignored.
REQ-030 busy SHALL be 1 in every state except IDLE-before-first-byte and DONE.
REQ-031 mem_we SHALL be 0 in every state except WRITE.
REQ-032 mem_data and mem_ad SHALL hold their last values when mem_we is 0.
REQ-033 err, once set, SHALL remain set until reset or start in DONE.

Reset
REQ-034 rst_n=0 at a rising edge SHALL force state IDLE and the following values: in_ready=1, mem_we=0, mem_ad=0, mem_data=0, busy=0, done=0, err=0, cpu_rst_n=0.
REQ-035 Reset mid-load SHALL abandon the load; already-written memory words are not restored, and the next accepted byte is treated as a new N.
REQ-036 rst_n SHALL take priority over all other inputs, including a simultaneous handshake or start.

Verification
REQ-037 Stream 01,00,28,01,28 -> one mem_we pulse with ad=00 and data=17'h12800, then done=1, err=0, cpu_rst_n=1.
REQ-038 Stream 02,03,00,00,07,00,00,06 -> writes 17'h00003 at ad 00 and 17'h00007 at ad 01, consecutive addresses, err=0.
REQ-039 Stream 00,00 -> no mem_we pulse; done=1, err=0. Stream 00,55 -> done=1, err=1.
REQ-040 Stream 01,FF,FF,03,<correct XOR> -> writes 17'h1FFFF and sets err=1 (format violation).
REQ-041 in_valid toggled randomly with valid data -> identical memory contents to the back-to-back case; in_ready=0 exactly in WRITE and DONE.
REQ-042 rst_n=0 after 4 bytes of a 2-word load, then a fresh 01,.. stream -> load restarts at ad 00 and the final state is clean done.
